// File: rtl/mem_pkg.sv
// mem_pkg: access-size encodings and FSM state type shared by the memory access unit.
package mem_pkg;
    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte enables, store-lane replication and load extraction/extension.
module mem_lane_align import mem_pkg::*; (
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata_in,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_offset,
    input  logic        ld_signed,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    always_comb begin
        be = size == SZ_HALF ? 4'b0011 << {offset[1], 1'b0} :
             size == SZ_BYTE ? 4'b0001 << offset : 4'b1111;
        wdata_rep = size == SZ_HALF ? {2{wdata_in[15:0]}} :
                    size == SZ_BYTE ? {4{wdata_in[7:0]}} : wdata_in;
        lane_b = rdata[{ld_offset, 3'b000} +: 8];
        lane_h = ld_offset[1] ? rdata[31:16] : rdata[15:0];
        rdata_ext = ld_size == SZ_HALF ? {{16{ld_signed & lane_h[15]}}, lane_h} :
                    ld_size == SZ_BYTE ? {{24{ld_signed & lane_b[7]}}, lane_b} : rdata;
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: stalls the pipeline while a single load/store runs on a req/ack memory port.
module mem_access_unit import mem_pkg::*; #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadIn,
    input  logic        MemWriteIn,
    input  logic [1:0]  MemSizeIn,
    input  logic        MemSignedIn,
    input  logic [31:0] AddressIn,
    input  logic [31:0] WriteDataIn,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ReadDataOut,
    output logic        Stall,
    output logic        AlignErr,
    output logic        TimeoutErr
);
    state_t      state;
    logic        access, aligned, we_q, sgn_q;
    logic [1:0]  size_q, off_q;
    logic [7:0]  cnt;
    logic [3:0]  be_n;
    logic [31:0] wdata_n, rdata_ext;

    mem_lane_align u_lane (
        .size(MemSizeIn), .offset(AddressIn[1:0]), .wdata_in(WriteDataIn),
        .ld_size(size_q), .ld_offset(off_q), .ld_signed(sgn_q), .rdata(mem_rdata),
        .be(be_n), .wdata_rep(wdata_n), .rdata_ext(rdata_ext)
    );

    always_comb begin
        access  = MemReadIn | MemWriteIn;
        aligned = MemSizeIn == SZ_BYTE ? 1'b1 :
                  MemSizeIn == SZ_HALF ? !AddressIn[0] : AddressIn[1:0] == 2'b00;
        Stall   = !reset && ((state == IDLE && access && aligned) || state == WAIT);
        mem_req = state == WAIT;
        mem_we  = mem_req & we_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ReadDataOut <= '0;
            mem_addr    <= '0;
            mem_be      <= '0;
            mem_wdata   <= '0;
            cnt         <= '0;
            AlignErr    <= 1'b0;
            TimeoutErr  <= 1'b0;
            we_q        <= 1'b0;
            sgn_q       <= 1'b0;
            size_q      <= '0;
            off_q       <= '0;
        end else begin
            AlignErr   <= 1'b0;
            TimeoutErr <= 1'b0;
            case (state)
                IDLE: begin
                    if (access && aligned) begin
                        state     <= WAIT;
                        cnt       <= '0;
                        mem_addr  <= {AddressIn[31:2], 2'b00};
                        mem_be    <= be_n;
                        mem_wdata <= wdata_n;
                        we_q      <= MemWriteIn;
                        sgn_q     <= MemSignedIn;
                        size_q    <= MemSizeIn;
                        off_q     <= AddressIn[1:0];
                    end else if (access) begin
                        AlignErr    <= 1'b1;
                        ReadDataOut <= '0;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        state <= DONE;
                        if (!we_q) ReadDataOut <= rdata_ext;
                    end else begin
                        cnt <= cnt + 8'd1;
                        if (cnt == 8'(ACK_TIMEOUT - 1)) begin
                            state       <= DONE;
                            TimeoutErr  <= 1'b1;
                            ReadDataOut <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed accesses with a scoreboard of expected port activity and results.
module tb_mem_access_unit;
    logic        clk = 0, reset = 1;
    logic        MemReadIn = 0, MemWriteIn = 0, MemSignedIn = 0, mem_ack = 0;
    logic [1:0]  MemSizeIn = 0;
    logic [31:0] AddressIn = 0, WriteDataIn = 0, mem_rdata = 0;
    logic        mem_req, mem_we, Stall, AlignErr, TimeoutErr;
    logic [31:0] mem_addr, mem_wdata, ReadDataOut;
    logic [3:0]  mem_be;
    int n_chk = 0, n_pass = 0;

    typedef struct {
        logic [31:0] addr, wdata, rdo;
        logic [3:0]  be;
        logic        we, tmo;
        int          stall, req;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    mem_access_unit #(.ACK_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn),
        .MemSizeIn(MemSizeIn), .MemSignedIn(MemSignedIn), .AddressIn(AddressIn),
        .WriteDataIn(WriteDataIn), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ReadDataOut(ReadDataOut), .Stall(Stall), .AlignErr(AlignErr), .TimeoutErr(TimeoutErr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // ack_cyc selects the WAIT cycle (1-based) that sees mem_ack; 0 never acks
    task automatic access(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rdat, input int ack_cyc, input exp_t e);
        exp_t x;
        int   st = 0, rq = 0;
        logic prev = 0;
        bit   done = 0;
        sb.push_back(e);
        MemReadIn = rd; MemWriteIn = wr; MemSizeIn = sz; MemSignedIn = sg;
        AddressIn = a; WriteDataIn = wd; mem_rdata = rdat;
        for (int c = 0; c < 64 && !done; c++) begin
            #1;
            if (prev && !mem_req) done = 1;
            else begin
                if (Stall) st++;
                if (mem_req) rq++;
                if (mem_req && rq == 1) begin
                    x = sb.pop_front();
                    chk({tag, ".addr"}, mem_addr, x.addr);
                    chk({tag, ".be"}, 32'(mem_be), 32'(x.be));
                    chk({tag, ".wdata"}, mem_wdata, x.wdata);
                    chk({tag, ".we"}, 32'(mem_we), 32'(x.we));
                end
                mem_ack = mem_req && rq == ack_cyc;
                prev = mem_req;
                @(negedge clk);
            end
        end
        mem_ack = 0; MemReadIn = 0; MemWriteIn = 0;
        chk({tag, ".finished"}, 32'(done), 32'd1);
        if (done) begin
            chk({tag, ".rdo"}, ReadDataOut, x.rdo);
            chk({tag, ".tmo"}, 32'(TimeoutErr), 32'(x.tmo));
            chk({tag, ".stall_cycles"}, 32'(st), 32'(x.stall));
            chk({tag, ".wait_cycles"}, 32'(rq), 32'(x.req));
            chk({tag, ".done_stall"}, 32'(Stall), 32'd0);
        end
        @(negedge clk);
        #1;
        chk({tag, ".idle_req"}, 32'(mem_req), 32'd0);
        chk({tag, ".idle_hold"}, ReadDataOut, x.rdo);
    endtask

    initial begin
        MemReadIn = 1; AddressIn = 32'h100;
        repeat (2) @(negedge clk);
        #1;
        chk("rst.stall", 32'(Stall), 0);
        chk("rst.req", 32'(mem_req), 0);
        chk("rst.rdo", ReadDataOut, 0);
        chk("rst.addr", mem_addr, 0);
        chk("rst.be", 32'(mem_be), 0);
        chk("rst.wdata", mem_wdata, 0);
        chk("rst.errs", {30'd0, AlignErr, TimeoutErr}, 0);
        MemReadIn = 0; reset = 0;
        @(negedge clk);

        access("lw", 1, 0, 2'b00, 0, 32'h100, 0, 32'hDEADBEEF, 2,
               '{addr:32'h100, wdata:0, rdo:32'hDEADBEEF, be:4'hF, we:0, tmo:0, stall:3, req:2});
        access("lb", 1, 0, 2'b10, 1, 32'h103, 0, 32'h80112233, 1,
               '{addr:32'h100, wdata:0, rdo:32'hFFFFFF80, be:4'h8, we:0, tmo:0, stall:2, req:1});
        access("lbu", 1, 0, 2'b10, 0, 32'h103, 0, 32'h80112233, 1,
               '{addr:32'h100, wdata:0, rdo:32'h00000080, be:4'h8, we:0, tmo:0, stall:2, req:1});
        access("lh", 1, 0, 2'b01, 1, 32'h102, 0, 32'h80112233, 1,
               '{addr:32'h100, wdata:0, rdo:32'hFFFF8011, be:4'hC, we:0, tmo:0, stall:2, req:1});
        access("lhu", 1, 0, 2'b01, 0, 32'h100, 0, 32'h80112233, 1,
               '{addr:32'h100, wdata:0, rdo:32'h00002233, be:4'h3, we:0, tmo:0, stall:2, req:1});
        access("sh", 0, 1, 2'b01, 0, 32'h102, 32'h0000ABCD, 32'hFFFFFFFF, 1,
               '{addr:32'h100, wdata:32'hABCDABCD, rdo:32'h00002233, be:4'hC, we:1, tmo:0, stall:2, req:1});
        access("sb_rw", 1, 1, 2'b10, 0, 32'h101, 32'h0012345A, 32'hFFFFFFFF, 1,
               '{addr:32'h100, wdata:32'h5A5A5A5A, rdo:32'h00002233, be:4'h2, we:1, tmo:0, stall:2, req:1});

        MemReadIn = 1; MemSizeIn = 2'b00; AddressIn = 32'h101;
        #1;
        chk("mis.stall", 32'(Stall), 0);
        @(negedge clk);
        #1;
        chk("mis.alignerr", 32'(AlignErr), 1);
        chk("mis.rdo", ReadDataOut, 0);
        chk("mis.req", 32'(mem_req), 0);
        MemSizeIn = 2'b01; AddressIn = 32'h103;
        @(negedge clk);
        #1;
        chk("mish.alignerr", 32'(AlignErr), 1);
        chk("mish.req", 32'(mem_req), 0);
        MemReadIn = 0;
        @(negedge clk);
        #1;
        chk("mis.pulse_end", 32'(AlignErr), 0);

        access("lw_sz3", 1, 0, 2'b11, 0, 32'h204, 32'h11223344, 32'h13579BDF, 3,
               '{addr:32'h204, wdata:32'h11223344, rdo:32'h13579BDF, be:4'hF, we:0, tmo:0, stall:4, req:3});

        MemReadIn = 1; MemSizeIn = 2'b00; AddressIn = 32'h300; mem_rdata = 32'h0BADF00D;
        repeat (3) @(negedge clk);
        #1;
        chk("rstw.req_w3", 32'(mem_req), 1);
        reset = 1;
        #1;
        chk("rstw.stall", 32'(Stall), 0);
        @(negedge clk);
        reset = 0; MemReadIn = 0; mem_ack = 1;
        #1;
        chk("rstw.req", 32'(mem_req), 0);
        chk("rstw.rdo", ReadDataOut, 0);
        chk("rstw.addr", mem_addr, 0);
        chk("rstw.be", 32'(mem_be), 0);
        chk("rstw.wdata", mem_wdata, 0);
        chk("rstw.stall_after", 32'(Stall), 0);
        @(negedge clk);
        mem_ack = 0;
        #1;
        chk("rstw.late_ack_rdo", ReadDataOut, 0);
        chk("rstw.late_ack_req", 32'(mem_req), 0);
        chk("rstw.errs", {30'd0, AlignErr, TimeoutErr}, 0);

        access("lbu2", 1, 0, 2'b10, 0, 32'h100, 0, 32'h13579BDF, 1,
               '{addr:32'h100, wdata:0, rdo:32'h000000DF, be:4'h1, we:0, tmo:0, stall:2, req:1});
        access("tmo", 1, 0, 2'b00, 0, 32'h200, 0, 32'h55555555, 0,
               '{addr:32'h200, wdata:0, rdo:32'h0, be:4'hF, we:0, tmo:1, stall:17, req:16});
        #1;
        chk("tmo.pulse_end", 32'(TimeoutErr), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
